fpga_bram_seq: RTL and testbench

Memory-side command sequencer for the FPGA BRAM link.
- Pops 36-bit command words from the CPU-to-FPGA FIFO and decodes read/write bursts.
- Drives a single-port BRAM (1-cycle read latency).
- Pushes read data, write acks and error responses into the FPGA-to-CPU FIFO.
- Sits between the link FIFOs and the BRAM primitive; it is the sequencer behind the mem modport.

---
 rtl/fpga_bram_seq_if.sv | 45 ++++
 rtl/fpga_bram_seq.sv | 191 +++++++++++++++++++
 tb/tb_fpga_bram_seq.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_bram_seq_if.sv
// Link bundle behind the mem modport: command FIFO pop side, response FIFO push side
// and BRAM port A. master = sequencer side, slave = FIFO/BRAM side.
interface fpga_bram_seq_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  empty_CPU_to_FPGA_FIFO;
   logic [35:0]           data_out_CPU_to_FPGA_FIFO;
   logic                  r_en_CPU_to_FPGA_FIFO;
   logic                  full_FPGA_to_CPU_FIFO;
   logic                  w_en_FPGA_to_CPU_FIFO;
   logic [35:0]           data_in_FPGA_to_CPU_FIFO;
   logic [ADDR_WIDTH-1:0] bram_addra;
   logic [31:0]           bram_dina;
   logic                  bram_wea;
   logic                  bram_ena;
   logic [31:0]           bram_douta;

   modport master (
      input  empty_CPU_to_FPGA_FIFO,
      input  data_out_CPU_to_FPGA_FIFO,
      output r_en_CPU_to_FPGA_FIFO,
      input  full_FPGA_to_CPU_FIFO,
      output w_en_FPGA_to_CPU_FIFO,
      output data_in_FPGA_to_CPU_FIFO,
      output bram_addra,
      output bram_dina,
      output bram_wea,
      output bram_ena,
      input  bram_douta
   );

   modport slave (
      output empty_CPU_to_FPGA_FIFO,
      output data_out_CPU_to_FPGA_FIFO,
      input  r_en_CPU_to_FPGA_FIFO,
      output full_FPGA_to_CPU_FIFO,
      input  w_en_FPGA_to_CPU_FIFO,
      input  data_in_FPGA_to_CPU_FIFO,
      input  bram_addra,
      input  bram_dina,
      input  bram_wea,
      input  bram_ena,
      output bram_douta
   );
endinterface

// File: rtl/fpga_bram_seq.sv
// Memory-side command sequencer: decodes read/write bursts from the command FIFO, drives a
// 1-cycle-latency BRAM and returns responses. `FPGA_BRAM_SEQ_ERR_FLUSH_EN adds a FLUSH state.
module fpga_bram_seq #(
   parameter int ADDR_WIDTH = 10,
   parameter int BURST_LEN  = 4
) (
   input  logic            fpga_clk,
   input  logic            rst,
   fpga_bram_seq_if.master bus,
   output logic            busy,
   output logic            error
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] RD_ISSUE = 3'd1;
   localparam logic [2:0] RD_WAIT  = 3'd2;
   localparam logic [2:0] RD_PUSH  = 3'd3;
   localparam logic [2:0] WR_DATA  = 3'd4;
   localparam logic [2:0] WR_ACK   = 3'd5;
   localparam logic [2:0] ERR_RESP = 3'd6;
`ifdef FPGA_BRAM_SEQ_ERR_FLUSH_EN
   localparam logic [2:0] FLUSH    = 3'd7;
`endif

   localparam logic [3:0] TAG_RD_ADDR = 4'h1;
   localparam logic [3:0] TAG_WR_ADDR = 4'h2;
   localparam logic [3:0] TAG_WR_DATA = 4'h3;
   localparam logic [3:0] TAG_RD_DATA = 4'h4;
   localparam logic [3:0] TAG_WR_ACK  = 4'h5;
   localparam logic [3:0] TAG_ERROR   = 4'hF;
   localparam logic [3:0] LAST_BEAT   = 4'(BURST_LEN - 1);

   logic [2:0]            state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [ADDR_WIDTH-1:0] base, base_nxt;
   logic [3:0]            beat, beat_nxt;
   logic [31:0]           rdata, rdata_nxt;
   logic [31:0]           err_payload, err_payload_nxt;
   logic                  error_nxt;

   logic [3:0]            head_tag;
   logic [31:0]           head_payload;
   logic                  head_legal;
   logic                  head_is_addr;

   assign head_tag     = bus.data_out_CPU_to_FPGA_FIFO[35:32];
   assign head_payload = bus.data_out_CPU_to_FPGA_FIFO[31:0];
   assign head_legal   = (head_payload >> ADDR_WIDTH) == 32'd0;
   assign head_is_addr = (head_tag == TAG_RD_ADDR) || (head_tag == TAG_WR_ADDR);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_nxt       = state;
      addr_nxt        = addr;
      base_nxt        = base;
      beat_nxt        = beat;
      rdata_nxt       = rdata;
      err_payload_nxt = err_payload;
      error_nxt       = error;

      bus.r_en_CPU_to_FPGA_FIFO    = 1'b0;
      bus.w_en_FPGA_to_CPU_FIFO    = 1'b0;
      bus.data_in_FPGA_to_CPU_FIFO = '0;
      bus.bram_addra               = '0;
      bus.bram_dina                = '0;
      bus.bram_wea                 = 1'b0;
      bus.bram_ena                 = 1'b0;

      case (state)
         IDLE: begin
            if (!bus.empty_CPU_to_FPGA_FIFO) begin
               bus.r_en_CPU_to_FPGA_FIFO = 1'b1;
               if (head_is_addr && head_legal) begin
                  base_nxt  = head_payload[ADDR_WIDTH-1:0];
                  addr_nxt  = head_payload[ADDR_WIDTH-1:0];
                  beat_nxt  = '0;
                  state_nxt = (head_tag == TAG_RD_ADDR) ? RD_ISSUE : WR_DATA;
               end else begin
                  err_payload_nxt = head_payload;
                  state_nxt       = ERR_RESP;
               end
            end
         end

         WR_DATA: begin
            if (!bus.empty_CPU_to_FPGA_FIFO) begin
               if (head_tag == TAG_WR_DATA) begin
                  bus.r_en_CPU_to_FPGA_FIFO = 1'b1;
                  bus.bram_ena              = 1'b1;
                  bus.bram_wea              = 1'b1;
                  bus.bram_addra            = addr;
                  bus.bram_dina             = head_payload;
                  addr_nxt                  = addr + ADDR_WIDTH'(1);
                  beat_nxt                  = beat + 4'd1;
                  if (beat == LAST_BEAT) state_nxt = WR_ACK;
               end else begin
                  // The offending word stays in the FIFO and is decoded as the next command.
                  err_payload_nxt = head_payload;
                  state_nxt       = ERR_RESP;
               end
            end
         end

         WR_ACK: begin
            if (!bus.full_FPGA_to_CPU_FIFO) begin
               bus.w_en_FPGA_to_CPU_FIFO    = 1'b1;
               bus.data_in_FPGA_to_CPU_FIFO = {TAG_WR_ACK, 32'(base)};
               state_nxt                    = IDLE;
            end
         end

         RD_ISSUE: begin
            bus.bram_ena   = 1'b1;
            bus.bram_addra = addr;
            state_nxt      = RD_WAIT;
         end

         RD_WAIT: begin
            rdata_nxt = bus.bram_douta;
            state_nxt = RD_PUSH;
         end

         RD_PUSH: begin
            if (!bus.full_FPGA_to_CPU_FIFO) begin
               bus.w_en_FPGA_to_CPU_FIFO    = 1'b1;
               bus.data_in_FPGA_to_CPU_FIFO = {TAG_RD_DATA, rdata};
               addr_nxt                     = addr + ADDR_WIDTH'(1);
               beat_nxt                     = beat + 4'd1;
               state_nxt                    = (beat == LAST_BEAT) ? IDLE : RD_ISSUE;
            end
         end

         ERR_RESP: begin
            if (!bus.full_FPGA_to_CPU_FIFO) begin
               bus.w_en_FPGA_to_CPU_FIFO    = 1'b1;
               bus.data_in_FPGA_to_CPU_FIFO = {TAG_ERROR, err_payload};
               error_nxt                    = 1'b1;
`ifdef FPGA_BRAM_SEQ_ERR_FLUSH_EN
               state_nxt                    = FLUSH;
`else
               state_nxt                    = IDLE;
`endif
            end
         end

`ifdef FPGA_BRAM_SEQ_ERR_FLUSH_EN
         FLUSH: begin
            if (!bus.empty_CPU_to_FPGA_FIFO) begin
               if (head_is_addr) state_nxt = IDLE;
               else              bus.r_en_CPU_to_FPGA_FIFO = 1'b1;
            end
         end
`endif

         default: state_nxt = IDLE;
      endcase

      // No FIFO or BRAM side effects while reset is held.
      if (!rst) begin
         bus.r_en_CPU_to_FPGA_FIFO    = 1'b0;
         bus.w_en_FPGA_to_CPU_FIFO    = 1'b0;
         bus.data_in_FPGA_to_CPU_FIFO = '0;
         bus.bram_addra               = '0;
         bus.bram_dina                = '0;
         bus.bram_wea                 = 1'b0;
         bus.bram_ena                 = 1'b0;
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
   always_ff @(posedge fpga_clk) begin
      if (!rst) begin
         state       <= IDLE;
         addr        <= '0;
         base        <= '0;
         beat        <= '0;
         rdata       <= '0;
         err_payload <= '0;
         error       <= 1'b0;
      end else begin
         state       <= state_nxt;
         addr        <= addr_nxt;
         base        <= base_nxt;
         beat        <= beat_nxt;
         rdata       <= rdata_nxt;
         err_payload <= err_payload_nxt;
         error       <= error_nxt;
      end
   end

   assign busy = (state != IDLE);
endmodule

// File: tb/tb_fpga_bram_seq.sv
// Bench for fpga_bram_seq: FIFO/BRAM environment models, a directed vector table, hand-written
// stall/latency/reset sequences and random command streams against a stream-level reference model.
module tb_fpga_bram_seq;
   localparam int AW    = 10;
   localparam int BL    = 4;
   localparam int DEPTH = 1 << AW;
   localparam int NV    = 6;

   logic fpga_clk = 1'b0;
   logic rst;
   logic busy;
   logic error;

   fpga_bram_seq_if #(.ADDR_WIDTH(AW)) bus ();

   fpga_bram_seq #(.ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
      .fpga_clk (fpga_clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .error    (error)
   );

   always #5 fpga_clk = ~fpga_clk;

   typedef struct {
      string            name;
      int               ncmd;
      logic [7:0][35:0] cmd;
      int               nrsp;
      logic [5:0][35:0] rsp;
      logic             err;
      int               nena;
   } vec_t;

   vec_t        vecs[NV];
   logic [35:0] cmd_q[$];
   logic [35:0] rsp_q[$];
   int          pop_cyc_q[$];
   int          rsp_cyc_q[$];
   logic [35:0] stream[$];
   logic [35:0] exp_rsp[$];
   logic        exp_err;
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic        full_force;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          ena_cnt = 0;
   int          wea_cnt = 0;

   function automatic logic [35:0] w(input logic [3:0] tag, input logic [31:0] payload);
      return {tag, payload};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive();
      bus.empty_CPU_to_FPGA_FIFO    = (cmd_q.size() == 0);
      bus.data_out_CPU_to_FPGA_FIFO = (cmd_q.size() == 0) ? 36'h0 : cmd_q[0];
      bus.full_FPGA_to_CPU_FIFO     = full_force;
   endtask

   // One clock: sample DUT strobes mid-cycle, then apply FIFO/BRAM effects just after the edge.
   task automatic cycle();
      logic          s_r_en, s_w_en, s_ena, s_wea, s_empty, s_full;
      logic [35:0]   s_din;
      logic [AW-1:0] s_addr;
      logic [31:0]   s_wdata;
      @(negedge fpga_clk);
      s_r_en  = bus.r_en_CPU_to_FPGA_FIFO;
      s_w_en  = bus.w_en_FPGA_to_CPU_FIFO;
      s_ena   = bus.bram_ena;
      s_wea   = bus.bram_wea;
      s_empty = bus.empty_CPU_to_FPGA_FIFO;
      s_full  = bus.full_FPGA_to_CPU_FIFO;
      s_din   = bus.data_in_FPGA_to_CPU_FIFO;
      s_addr  = bus.bram_addra;
      s_wdata = bus.bram_dina;
      check("pop_while_empty", 64'(s_r_en & s_empty), 64'd0);
      check("push_while_full", 64'(s_w_en & s_full), 64'd0);
      @(posedge fpga_clk);
      #1;
      cyc++;
      if (!rst) begin
         cmd_q.delete();
      end else if (s_r_en && cmd_q.size() > 0) begin
         void'(cmd_q.pop_front());
         pop_cyc_q.push_back(cyc);
      end
      if (s_w_en) begin
         rsp_q.push_back(s_din);
         rsp_cyc_q.push_back(cyc);
      end
      if (s_ena) begin
         ena_cnt++;
         if (s_wea) begin
            mem[s_addr] = s_wdata;
            wea_cnt++;
         end else begin
            bus.bram_douta = mem[s_addr];
         end
      end
      drive();
   endtask

   task automatic clear_logs();
      rsp_q.delete();
      pop_cyc_q.delete();
      rsp_cyc_q.delete();
      ena_cnt = 0;
      wea_cnt = 0;
   endtask

   task automatic do_reset(input string name);
      rst        = 1'b0;
      full_force = 1'b0;
      drive();
      cycle();
      cycle();
      rst = 1'b1;
      drive();
      clear_logs();
      check({name, "_rst_busy"},  64'(busy), 64'd0);
      check({name, "_rst_error"}, 64'(error), 64'd0);
      check({name, "_rst_strobes"}, 64'({bus.r_en_CPU_to_FPGA_FIFO, bus.w_en_FPGA_to_CPU_FIFO,
                                         bus.bram_ena, bus.bram_wea}), 64'd0);
      check({name, "_rst_buses"}, 64'(bus.data_in_FPGA_to_CPU_FIFO) | 64'(bus.bram_addra)
                                  | 64'(bus.bram_dina), 64'd0);
   endtask

   task automatic run_until(input int nrsp, input int budget, input string name);
      int c = 0;
      while (!(rsp_q.size() >= nrsp && cmd_q.size() == 0) && c < budget) begin
         cycle();
         c++;
      end
      check({name, "_in_time"}, 64'(c < budget), 64'd1);
      repeat (6) cycle();
   endtask

   task automatic check_rsp(input string name, input int k, input logic [35:0] exp);
      check($sformatf("%s_rsp%0d", name, k),
            (k < rsp_q.size()) ? 64'(rsp_q[k]) : {28'h0, 36'hx}, 64'(exp));
   endtask

   // Stream-level reference: walks the command words in order and applies the decode rules.
   task automatic model();
      int i = 0;
      exp_rsp.delete();
      exp_err = 1'b0;
      while (i < stream.size()) begin
         logic [3:0]  t;
         logic [31:0] p;
         int          b;
         bit          ok;
         t = stream[i][35:32];
         p = stream[i][31:0];
         i++;
         if ((t == 4'h1 || t == 4'h2) && p < DEPTH) begin
            if (t == 4'h1) begin
               for (int k = 0; k < BL; k++) exp_rsp.push_back({4'h4, ref_mem[(p + k) % DEPTH]});
            end else begin
               b  = 0;
               ok = 1'b1;
               while (b < BL && ok) begin
                  if (i >= stream.size()) begin
                     ok = 1'b0;
                     i  = stream.size();
                  end else if (stream[i][35:32] == 4'h3) begin
                     ref_mem[(p + b) % DEPTH] = stream[i][31:0];
                     i++;
                     b++;
                  end else begin
                     exp_rsp.push_back({4'hF, stream[i][31:0]});
                     exp_err = 1'b1;
                     ok      = 1'b0;
`ifdef FPGA_BRAM_SEQ_ERR_FLUSH_EN
                     while (i < stream.size() && stream[i][35:32] != 4'h1 && stream[i][35:32] != 4'h2) i++;
`endif
                  end
               end
               if (ok) exp_rsp.push_back({4'h5, p});
            end
         end else begin
            exp_rsp.push_back({4'hF, p});
            exp_err = 1'b1;
`ifdef FPGA_BRAM_SEQ_ERR_FLUSH_EN
            while (i < stream.size() && stream[i][35:32] != 4'h1 && stream[i][35:32] != 4'h2) i++;
`endif
         end
      end
   endtask

   task automatic random_test(input int nops, input string name);
      int fed = 0;
      int c   = 0;
      int nbad = 0;
      do_reset(name);
      stream.delete();
      for (int op = 0; op < nops; op++) begin
         int          k;
         int          n;
         int          t;
         logic [31:0] a;
         k = $urandom_range(0, 19);
         a = 32'($urandom_range(0, DEPTH - 1));
         if (k < 8) begin
            stream.push_back(w(4'h1, a));
         end else if (k < 15 || k == 19) begin
            if (k == 19) a = 32'(DEPTH - 1 - $urandom_range(0, 2));
            stream.push_back(w(4'h2, a));
            for (int b = 0; b < BL; b++) stream.push_back(w(4'h3, $urandom));
         end else if (k == 15) begin
            n = $urandom_range(0, BL - 1);
            stream.push_back(w(4'h2, a));
            for (int b = 0; b < n; b++) stream.push_back(w(4'h3, $urandom));
         end else if (k == 16) begin
            stream.push_back(w(4'($urandom_range(1, 2)), a | (32'd1 << $urandom_range(AW, 31))));
         end else if (k == 17) begin
            stream.push_back(w(4'h3, $urandom));
         end else begin
            t = $urandom_range(0, 12);
            if (t >= 1) t += 3;
            stream.push_back(w(4'(t), $urandom));
         end
      end
      stream.push_back(w(4'h1, 32'($urandom_range(0, DEPTH - 1))));
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = mem[i];
      model();
      while (!(fed == stream.size() && cmd_q.size() == 0 && rsp_q.size() >= exp_rsp.size())
             && c < 30000) begin
         if (fed < stream.size() && $urandom_range(0, 9) < 7) begin
            cmd_q.push_back(stream[fed]);
            fed++;
         end
         full_force = ($urandom_range(0, 3) == 0);
         drive();
         cycle();
         c++;
      end
      check({name, "_in_time"}, 64'(c < 30000), 64'd1);
      full_force = 1'b0;
      drive();
      repeat (8) cycle();
      check({name, "_count"}, 64'(rsp_q.size()), 64'(exp_rsp.size()));
      for (int k = 0; k < exp_rsp.size(); k++) check_rsp(name, k, exp_rsp[k]);
      check({name, "_error"}, 64'(error), 64'(exp_err));
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
      check({name, "_mem_image"}, 64'(nbad), 64'd0);
   endtask

   initial begin
      int j;
      rst            = 1'b0;
      full_force     = 1'b0;
      bus.bram_douta = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC000_0000 | 32'(i);
      drive();

      vecs[0].name = "wr_rd_010"; vecs[0].ncmd = 6; vecs[0].nrsp = 5; vecs[0].err = 1'b0; vecs[0].nena = 8;
      vecs[0].cmd[0] = w(4'h2, 32'h010);
      for (int i = 0; i < 4; i++) vecs[0].cmd[1 + i] = w(4'h3, 32'hA0 + 32'(i));
      vecs[0].cmd[5] = w(4'h1, 32'h010);
      vecs[0].rsp[0] = w(4'h5, 32'h010);
      for (int i = 0; i < 4; i++) vecs[0].rsp[1 + i] = w(4'h4, 32'hA0 + 32'(i));

      vecs[1].name = "wrap_3fe"; vecs[1].ncmd = 6; vecs[1].nrsp = 5; vecs[1].err = 1'b0; vecs[1].nena = 8;
      vecs[1].cmd[0] = w(4'h2, 32'h3FE);
      for (int i = 0; i < 4; i++) vecs[1].cmd[1 + i] = w(4'h3, 32'hB0 + 32'(i));
      vecs[1].cmd[5] = w(4'h1, 32'h3FE);
      vecs[1].rsp[0] = w(4'h5, 32'h3FE);
      for (int i = 0; i < 4; i++) vecs[1].rsp[1 + i] = w(4'h4, 32'hB0 + 32'(i));

      vecs[2].name = "illegal_rd"; vecs[2].ncmd = 1; vecs[2].nrsp = 1; vecs[2].err = 1'b1; vecs[2].nena = 0;
      vecs[2].cmd[0] = w(4'h1, 32'h400);
      vecs[2].rsp[0] = w(4'hF, 32'h400);

      vecs[3].name = "short_wr"; vecs[3].ncmd = 4; vecs[3].nrsp = 5; vecs[3].err = 1'b1; vecs[3].nena = 6;
      vecs[3].cmd[0] = w(4'h2, 32'h020);
      vecs[3].cmd[1] = w(4'h3, 32'hD0);
      vecs[3].cmd[2] = w(4'h3, 32'hD1);
      vecs[3].cmd[3] = w(4'h1, 32'h020);
      vecs[3].rsp[0] = w(4'hF, 32'h020);
      vecs[3].rsp[1] = w(4'h4, 32'hD0);
      vecs[3].rsp[2] = w(4'h4, 32'hD1);
      vecs[3].rsp[3] = w(4'h4, 32'hC000_0022);
      vecs[3].rsp[4] = w(4'h4, 32'hC000_0023);

      vecs[4].name = "stray"; vecs[4].ncmd = 3; vecs[4].err = 1'b1; vecs[4].nena = 4;
      vecs[4].cmd[0] = w(4'h7, 32'h1234);
      vecs[4].cmd[1] = w(4'h3, 32'h55);
      vecs[4].cmd[2] = w(4'h1, 32'h010);
      vecs[4].rsp[0] = w(4'hF, 32'h1234);
      j = 1;
`ifndef FPGA_BRAM_SEQ_ERR_FLUSH_EN
      vecs[4].rsp[1] = w(4'hF, 32'h55);
      j = 2;
`endif
      for (int i = 0; i < 4; i++) vecs[4].rsp[j + i] = w(4'h4, 32'hA0 + 32'(i));
      vecs[4].nrsp = j + 4;

      vecs[5].name = "illegal_wr"; vecs[5].ncmd = 1; vecs[5].nrsp = 1; vecs[5].err = 1'b1; vecs[5].nena = 0;
      vecs[5].cmd[0] = w(4'h2, 32'h8000_0000);
      vecs[5].rsp[0] = w(4'hF, 32'h8000_0000);

      for (int r = 0; r < NV; r++) begin
         do_reset(vecs[r].name);
         for (int c = 0; c < vecs[r].ncmd; c++) cmd_q.push_back(vecs[r].cmd[c]);
         drive();
         run_until(vecs[r].nrsp, 200, vecs[r].name);
         check({vecs[r].name, "_count"}, 64'(rsp_q.size()), 64'(vecs[r].nrsp));
         for (int k = 0; k < vecs[r].nrsp; k++) check_rsp(vecs[r].name, k, vecs[r].rsp[k]);
         check({vecs[r].name, "_error"}, 64'(error), 64'(vecs[r].err));
         check({vecs[r].name, "_bram_accesses"}, 64'(ena_cnt), 64'(vecs[r].nena));
      end
      for (int i = 0; i < 4; i++) begin
         check($sformatf("mem_010_%0d", i), 64'(mem[16 + i]), 64'(32'hA0 + 32'(i)));
         check($sformatf("mem_wrap_%0d", i), 64'(mem[(1022 + i) % DEPTH]), 64'(32'hB0 + 32'(i)));
      end
      check("mem_020", 64'(mem[32]), 64'h0D0);
      check("mem_021", 64'(mem[33]), 64'h0D1);

      // Read latency and beat spacing.
      do_reset("lat_rd");
      cmd_q.push_back(w(4'h1, 32'h011));
      drive();
      run_until(4, 100, "lat_rd");
      check("lat_rd_first", 64'(rsp_cyc_q[0] - pop_cyc_q[0]), 64'd3);
      check("lat_rd_beat", 64'(rsp_cyc_q[1] - rsp_cyc_q[0]), 64'd3);
      check_rsp("lat_rd", 0, w(4'h4, 32'hA1));

      // Write throughput and ack timing.
      do_reset("lat_wr");
      cmd_q.push_back(w(4'h2, 32'h050));
      for (int i = 0; i < 4; i++) cmd_q.push_back(w(4'h3, 32'h5A0 + 32'(i)));
      drive();
      run_until(1, 100, "lat_wr");
      check("lat_wr_beats", 64'(pop_cyc_q[4] - pop_cyc_q[0]), 64'd4);
      check("lat_wr_ack", 64'(rsp_cyc_q[0] - pop_cyc_q[4]), 64'd1);
      check_rsp("lat_wr", 0, w(4'h5, 32'h050));
      check("lat_wr_mem", 64'(mem[83]), 64'h5A3);

      // Response FIFO full for 5 cycles across the second read beat.
      do_reset("full_stall");
      cmd_q.push_back(w(4'h1, 32'h010));
      drive();
      j = 0;
      while (rsp_q.size() < 1 && j < 20) begin
         cycle();
         j++;
      end
      full_force = 1'b1;
      drive();
      repeat (5) cycle();
      check("full_stall_held", 64'(rsp_q.size()), 64'd1);
      full_force = 1'b0;
      drive();
      run_until(4, 100, "full_stall");
      check("full_stall_count", 64'(rsp_q.size()), 64'd4);
      for (int k = 0; k < 4; k++) check_rsp("full_stall", k, w(4'h4, 32'hA0 + 32'(k)));
      check("full_stall_bram", 64'(ena_cnt), 64'd4);

      // Reset mid write burst, after two beats.
      do_reset("mid_rst");
      cmd_q.push_back(w(4'h2, 32'h040));
      for (int i = 0; i < 4; i++) cmd_q.push_back(w(4'h3, 32'hE0 + 32'(i)));
      drive();
      j = 0;
      while (wea_cnt < 2 && j < 20) begin
         cycle();
         j++;
      end
      rst = 1'b0;
      cycle();
      check("mid_rst_busy", 64'(busy), 64'd0);
      rst = 1'b1;
      drive();
      check("mid_rst_strobes", 64'({bus.r_en_CPU_to_FPGA_FIFO, bus.w_en_FPGA_to_CPU_FIFO,
                                    bus.bram_ena, bus.bram_wea}), 64'd0);
      check("mid_rst_error", 64'(error), 64'd0);
      repeat (10) cycle();
      check("mid_rst_no_ack", 64'(rsp_q.size()), 64'd0);
      check("mid_rst_writes", 64'(wea_cnt), 64'd2);
      cmd_q.push_back(w(4'h1, 32'h040));
      drive();
      run_until(4, 100, "mid_rst_rd");
      check_rsp("mid_rst_rd", 0, w(4'h4, 32'hE0));
      check_rsp("mid_rst_rd", 1, w(4'h4, 32'hE1));
      check_rsp("mid_rst_rd", 2, w(4'h4, 32'hC000_0042));
      check_rsp("mid_rst_rd", 3, w(4'h4, 32'hC000_0043));

      random_test(80, "rand_a");
      random_test(80, "rand_b");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
